// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, fills the
// IF/ID register, parks one word while decode is stalled, drains a
// redirected in-flight request, and stops on the halt opcode.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        halted
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {FETCH, BUF, DROP, HALT} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] pc, pc_nxt;
  logic [W-1:0] drop_addr, drop_addr_nxt;
  logic [W-1:0] buf_instr, buf_instr_nxt;
  logic [W-1:0] buf_pc2, buf_pc2_nxt;
  logic         if_valid_nxt;
  logic [W-1:0] if_instr_nxt, if_pc_plus2_nxt;
  logic         imem_req_nxt, halted_nxt;
  logic [W-1:0] imem_addr_nxt;

  logic [W-1:0] pc_plus2;
  logic [W-1:0] flush_pc;
  logic [W-1:0] reset_pc_even;
  logic         done;
  logic         fetch_is_halt;
  logic         buf_is_halt;

  // Shared datapath terms; addresses are forced even, PC wraps modulo 2^16.
  assign pc_plus2      = pc + W'(2);
  assign flush_pc      = flush_target & 16'hFFFE;
  assign reset_pc_even = RESET_PC & 16'hFFFE;
  assign done          = imem_req & imem_valid;
  assign fetch_is_halt = (imem_rdata[15:12] == HALT_OPCODE);
  assign buf_is_halt   = (buf_instr[15:12] == HALT_OPCODE);

  // Next-state and next-output decode; flush outranks stall everywhere.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drop_addr_nxt   = drop_addr;
    buf_instr_nxt   = buf_instr;
    buf_pc2_nxt     = buf_pc2;
    if_valid_nxt    = if_valid;
    if_instr_nxt    = if_instr;
    if_pc_plus2_nxt = if_pc_plus2;

    case (state)
      FETCH: begin
        if (flush) begin
          pc_nxt       = flush_pc;
          if_valid_nxt = 1'b0;
          if (!done) begin
            // Request still in flight: remember it so it can be drained.
            drop_addr_nxt = pc;
            state_nxt     = DROP;
          end
        end else if (done) begin
          if (!fetch_is_halt) pc_nxt = pc_plus2;
          if (stall) begin
            buf_instr_nxt = imem_rdata;
            buf_pc2_nxt   = pc_plus2;
            state_nxt     = BUF;
          end else begin
            if_valid_nxt    = 1'b1;
            if_instr_nxt    = imem_rdata;
            if_pc_plus2_nxt = pc_plus2;
            state_nxt       = fetch_is_halt ? HALT : FETCH;
          end
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
        end
      end
      BUF: begin
        if (flush) begin
          pc_nxt       = flush_pc;
          if_valid_nxt = 1'b0;
          state_nxt    = FETCH;
        end else if (!stall) begin
          if_valid_nxt    = 1'b1;
          if_instr_nxt    = buf_instr;
          if_pc_plus2_nxt = buf_pc2;
          state_nxt       = buf_is_halt ? HALT : FETCH;
        end
      end
      DROP: begin
        if_valid_nxt = 1'b0;
        if (flush) pc_nxt = flush_pc;
        if (done) state_nxt = FETCH;
      end
      HALT: begin
        if (flush) begin
          pc_nxt       = flush_pc;
          if_valid_nxt = 1'b0;
          state_nxt    = FETCH;
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = FETCH;
    endcase

    imem_req_nxt  = (state_nxt == FETCH) || (state_nxt == DROP);
    imem_addr_nxt = (state_nxt == DROP) ? drop_addr_nxt : pc_nxt;
    halted_nxt    = (state_nxt == HALT);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= reset_pc_even;
      drop_addr   <= '0;
      buf_instr   <= '0;
      buf_pc2     <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc_plus2 <= '0;
      imem_req    <= 1'b1;
      imem_addr   <= reset_pc_even;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop_addr   <= drop_addr_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_pc2     <= buf_pc2_nxt;
      if_valid    <= if_valid_nxt;
      if_instr    <= if_instr_nxt;
      if_pc_plus2 <= if_pc_plus2_nxt;
      imem_req    <= imem_req_nxt;
      imem_addr   <= imem_addr_nxt;
      halted      <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory responder with per-address
// latency, scoreboard of expected IF/ID entries consumed by decode.
`timescale 1ns/1ps
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_target = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        halted;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  exp_t        mon_exp;
  logic [15:0] mem [logic [15:0]];
  bit          slow_en = 1'b0;
  logic [15:0] slow_addr = 16'h0000;
  int          slow_lat = 0;
  bit          force_valid = 1'b0;
  int          wait_cnt = 0;
  int          resp_lat = 0;

  fetch_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .flush_target(flush_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc_plus2(if_pc_plus2), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h1000 | (a & 16'h0FFF);
  endfunction

  // Memory responder: answers after resp_lat waiting cycles.
  always @(negedge clk) begin
    resp_lat   = (slow_en && imem_addr == slow_addr) ? slow_lat : 0;
    imem_valid = force_valid || (imem_req && wait_cnt >= resp_lat);
    imem_rdata = force_valid ? 16'hF0F0 : mem_rd(imem_addr);
  end

  // Waiting-cycle counter for the outstanding request.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_valid) wait_cnt = 0;
    else wait_cnt = wait_cnt + 1;
  end

  // Scoreboard: an IF/ID entry is consumed at the next edge when not stalled.
  always @(negedge clk) begin
    if (!rst && if_valid && !stall) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got instr=%h pc2=%h required no entry", if_instr, if_pc_plus2);
      end else begin
        mon_exp = sb.pop_front();
        if ({if_instr, if_pc_plus2} !== mon_exp) begin
          errors++;
          $display("FAIL sb_entry got instr=%h pc2=%h required instr=%h pc2=%h",
                   if_instr, if_pc_plus2, mon_exp.instr, mon_exp.pc2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] p);
    sb.push_back(exp_t'({i, p}));
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; force_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_halted(input int max);
    int n = 0;
    while (!halted && n < max) begin
      step();
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_timeout got halted=%b required 1 within %0d cycles", halted, max);
    end
  endtask

  task automatic drain(input string name);
    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_leftover got %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b required 0", if_valid); end
    checks++; if (if_instr !== 16'h0000) begin errors++; $display("FAIL rst_if_instr got %h required 0000", if_instr); end
    checks++; if (if_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL rst_pc2 got %h required 0000", if_pc_plus2); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b required 0", halted); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b required 1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h required 0000", imem_addr); end
  endtask

  task automatic test_sequential();
    mem.delete();
    mem[16'h0000] = 16'h1000; mem[16'h0002] = 16'h2000; mem[16'h0004] = 16'hF000;
    push(16'h1000, 16'h0002); push(16'h2000, 16'h0004); push(16'hF000, 16'h0006);
    do_reset();
    step();
    checks++; if ({if_valid, if_instr, if_pc_plus2} !== {1'b1, 16'h1000, 16'h0002}) begin
      errors++; $display("FAIL seq_first got v=%b %h %h required 1 1000 0002", if_valid, if_instr, if_pc_plus2); end
    step();
    checks++; if ({if_valid, if_instr, if_pc_plus2} !== {1'b1, 16'h2000, 16'h0004}) begin
      errors++; $display("FAIL seq_second got v=%b %h %h required 1 2000 0004", if_valid, if_instr, if_pc_plus2); end
    wait_halted(20);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_halt_req got %b required 0", imem_req); end
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_halt_bubble got %b required 0", if_valid); end
    drain("seq");
  endtask

  task automatic test_stall_buf();
    mem.delete();
    mem[16'h0000] = 16'h1000; mem[16'h0002] = 16'h2000;
    mem[16'h0004] = 16'h3000; mem[16'h0006] = 16'hF000;
    push(16'h1000, 16'h0002); push(16'h2000, 16'h0004);
    push(16'h3000, 16'h0006); push(16'hF000, 16'h0008);
    do_reset();
    step(); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL buf_req[%0d] got %b required 0", i, imem_req); end
      checks++; if ({if_valid, if_instr, if_pc_plus2} !== {1'b1, 16'h2000, 16'h0004}) begin
        errors++; $display("FAIL buf_hold[%0d] got v=%b %h %h required 1 2000 0004", i, if_valid, if_instr, if_pc_plus2); end
    end
    stall = 1'b0;
    step();
    checks++; if ({if_valid, if_instr, if_pc_plus2} !== {1'b1, 16'h3000, 16'h0006}) begin
      errors++; $display("FAIL buf_release got v=%b %h %h required 1 3000 0006", if_valid, if_instr, if_pc_plus2); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin
      errors++; $display("FAIL buf_next_req got %b %h required 1 0006", imem_req, imem_addr); end
    wait_halted(10);
    drain("buf");
  endtask

  task automatic test_flush_drop();
    mem.delete();
    mem[16'h0100] = 16'hF000;
    slow_en = 1'b1; slow_addr = 16'h0008; slow_lat = 3;
    push(16'h1000, 16'h0002); push(16'h1002, 16'h0004); push(16'h1004, 16'h0006);
    push(16'h1006, 16'h0008); push(16'hF000, 16'h0102);
    do_reset();
    step(); step(); step(); step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0008}) begin
      errors++; $display("FAIL drop_pre got %b %h required 1 0008", imem_req, imem_addr); end
    flush = 1'b1; flush_target = 16'h0101;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0008, 1'b0}) begin
        errors++; $display("FAIL drop_hold[%0d] got req=%b addr=%h v=%b required 1 0008 0", i, imem_req, imem_addr, if_valid); end
      step();
    end
    checks++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0100, 1'b0}) begin
      errors++; $display("FAIL drop_redirect got req=%b addr=%h v=%b required 1 0100 0", imem_req, imem_addr, if_valid); end
    slow_en = 1'b0;
    wait_halted(10);
    drain("drop");
  endtask

  task automatic test_halt_flush();
    mem.delete();
    mem[16'h0010] = 16'hF000;
    for (int a = 0; a < 16; a += 2) push(16'h1000 | 16'(a), 16'(a + 2));
    push(16'hF000, 16'h0012);
    do_reset();
    wait_halted(40);
    step(); step();
    checks++; if ({halted, imem_req, if_valid} !== {1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL halt_state got halted=%b req=%b v=%b required 1 0 0", halted, imem_req, if_valid); end
    checks++; if (if_pc_plus2 !== 16'h0012) begin errors++; $display("FAIL halt_pc2 got %h required 0012", if_pc_plus2); end
    mem[16'h0020] = 16'hF000;
    push(16'hF000, 16'h0022);
    flush = 1'b1; flush_target = 16'h0020;
    step();
    flush = 1'b0;
    checks++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0020}) begin
      errors++; $display("FAIL halt_resume got halted=%b req=%b addr=%h required 0 1 0020", halted, imem_req, imem_addr); end
    wait_halted(10);
    drain("halt");
  endtask

  task automatic test_wrap();
    mem.delete();
    mem[16'hFFFE] = 16'h2345; mem[16'h0000] = 16'hF000;
    push(16'h2345, 16'h0000); push(16'hF000, 16'h0002);
    do_reset();
    flush = 1'b1; flush_target = 16'hFFFF;
    step();
    flush = 1'b0;
    checks++; if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'hFFFE}) begin
      errors++; $display("FAIL wrap_redirect got v=%b req=%b addr=%h required 0 1 fffe", if_valid, imem_req, imem_addr); end
    step();
    checks++; if ({if_instr, if_pc_plus2, imem_addr} !== {16'h2345, 16'h0000, 16'h0000}) begin
      errors++; $display("FAIL wrap_load got %h %h addr=%h required 2345 0000 0000", if_instr, if_pc_plus2, imem_addr); end
    wait_halted(10);
    drain("wrap");
  endtask

  task automatic test_reset_in_drop();
    mem.delete();
    slow_en = 1'b1; slow_addr = 16'h0040; slow_lat = 5;
    do_reset();
    flush = 1'b1; flush_target = 16'h0040;
    step();
    flush_target = 16'h0080;
    step();
    flush = 1'b0;
    checks++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      errors++; $display("FAIL rdrop_pre got req=%b addr=%h v=%b required 1 0040 0", imem_req, imem_addr, if_valid); end
    rst = 1'b1; force_valid = 1'b1;
    step();
    checks++; if ({if_valid, if_instr, if_pc_plus2, halted} !== {1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL rdrop_ifid got v=%b %h %h h=%b required 0 0000 0000 0", if_valid, if_instr, if_pc_plus2, halted); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL rdrop_req got %b %h required 1 0000", imem_req, imem_addr); end
    rst = 1'b0; force_valid = 1'b0; slow_en = 1'b0;
    mem[16'h0000] = 16'hF000;
    push(16'hF000, 16'h0002);
    wait_halted(10);
    drain("rdrop");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_buf();
    test_flush_drop();
    test_halt_flush();
    test_wrap();
    test_reset_in_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
